// File: rtl/riscv_bp_pkg.sv
// Shared definitions for the branch predictor: branch funct3 encodings and
// 2-bit saturating counter codes.
package riscv_bp_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

endpackage

// File: rtl/bp_sat_counter2.sv
// Combinational next-state for a 2-bit saturating direction counter.
module bp_sat_counter2
  import riscv_bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// Direct-mapped tagged BHT/BTB: fetch-side prediction, execute-side resolution,
// mispredict redirect and 2-bit counter training.
module branch_predictor_bht
  import riscv_bp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] PCF,
  output logic             PredTakenF,
  output logic [WIDTH-1:0] PredTargetF,
  input  logic             BranchE,
  input  logic [2:0]       funct3E,
  input  logic             ZeroE,
  input  logic [WIDTH-1:0] PCE,
  input  logic [WIDTH-1:0] PCTargetE,
  input  logic [WIDTH-1:0] PCPlus4E,
  input  logic             PredTakenE,
  output logic             ActualTakenE,
  output logic             MispredictE,
  output logic [WIDTH-1:0] RedirectPCE,
  output logic [31:0]      BranchCount,
  output logic [31:0]      MispredCount
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int TAG_W   = WIDTH - 2 - IDX_W;
  localparam logic [WIDTH-1:0] PC_INC = WIDTH'(4);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [WIDTH-1:0]   tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e;
  logic             taken_e, legal_e, br_e;
  logic [1:0]       ctr_next_e;

  // Instruction-aligned PCs: the two low bits never select anything.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[WIDTH-1:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[WIDTH-1:IDX_W+2];

  assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign PredTakenF  = hit_f && ctr_q[idx_f][1];
  assign PredTargetF = PredTakenF ? tgt_q[idx_f] : (PCF + PC_INC);

  // ZeroE comes from SUB for beq/bne and from SLT/SLTU for the ordered compares,
  // so blt* is taken when the set-less-than result is non-zero.
  always_comb begin
    taken_e = 1'b0;
    legal_e = 1'b0;
    case (funct3E)
      F3_BEQ, F3_BGE, F3_BGEU: begin
        legal_e = 1'b1;
        taken_e = ZeroE;
      end
      F3_BNE, F3_BLT, F3_BLTU: begin
        legal_e = 1'b1;
        taken_e = ~ZeroE;
      end
      default: begin
        legal_e = 1'b0;
        taken_e = 1'b0;
      end
    endcase
  end

  assign br_e         = BranchE && legal_e;
  assign ActualTakenE = br_e && taken_e;
  assign MispredictE  = br_e && (PredTakenE != taken_e);
  assign RedirectPCE  = taken_e ? PCTargetE : PCPlus4E;
  assign hit_e        = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  bp_sat_counter2 u_ctr (
    .ctr      (ctr_q[idx_e]),
    .taken    (taken_e),
    .ctr_next (ctr_next_e)
  );

  // Table training; reset takes priority over a same-cycle resolution.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= WNT;
      end
    end else if (br_e) begin
      if (hit_e) begin
        ctr_q[idx_e] <= ctr_next_e;
        if (taken_e) tgt_q[idx_e] <= PCTargetE;
      end else if (taken_e) begin
        valid_q[idx_e] <= 1'b1;
        tag_q[idx_e]   <= tag_e;
        tgt_q[idx_e]   <= PCTargetE;
        ctr_q[idx_e]   <= WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      BranchCount  <= '0;
      MispredCount <= '0;
    end else begin
      if (br_e)        BranchCount  <= BranchCount + 32'd1;
      if (MispredictE) MispredCount <= MispredCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Scoreboard bench: each driven cycle pushes hand-computed expectations, and a
// negedge monitor pops and compares them against the DUT outputs.
module tb_branch_predictor_bht;
  import riscv_bp_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        BranchE;
  logic [2:0]  funct3E;
  logic        ZeroE;
  logic [31:0] PCE;
  logic [31:0] PCTargetE;
  logic [31:0] PCPlus4E;
  logic        PredTakenE;
  logic        ActualTakenE;
  logic        MispredictE;
  logic [31:0] RedirectPCE;
  logic [31:0] BranchCount;
  logic [31:0] MispredCount;

  always #5 clk = ~clk;

  branch_predictor_bht #(.WIDTH(32), .IDX_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .PCF          (PCF),
    .PredTakenF   (PredTakenF),
    .PredTargetF  (PredTargetF),
    .BranchE      (BranchE),
    .funct3E      (funct3E),
    .ZeroE        (ZeroE),
    .PCE          (PCE),
    .PCTargetE    (PCTargetE),
    .PCPlus4E     (PCPlus4E),
    .PredTakenE   (PredTakenE),
    .ActualTakenE (ActualTakenE),
    .MispredictE  (MispredictE),
    .RedirectPCE  (RedirectPCE),
    .BranchCount  (BranchCount),
    .MispredCount (MispredCount)
  );

  typedef struct {
    string       name;
    logic        predTaken;
    logic [31:0] predTarget;
    logic        actual;
    logic        mispred;
    logic [31:0] redirect;
    logic [31:0] branchCnt;
    logic [31:0] mispredCnt;
  } exp_t;

  exp_t expQ[$];
  int   checksTotal  = 0;
  int   checksPassed = 0;

  task automatic cmp(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    checksTotal++;
    if (act === exp) checksPassed++;
    else $display("[TB] FAIL %s.%s actual=0x%08h expected=0x%08h", name, field, act, exp);
  endtask

  task automatic checkOutput(input exp_t e);
    cmp(e.name, "PredTakenF",   32'(PredTakenF),   32'(e.predTaken));
    cmp(e.name, "PredTargetF",  PredTargetF,       e.predTarget);
    cmp(e.name, "ActualTakenE", 32'(ActualTakenE), 32'(e.actual));
    cmp(e.name, "MispredictE",  32'(MispredictE),  32'(e.mispred));
    if (e.mispred) cmp(e.name, "RedirectPCE", RedirectPCE, e.redirect);
    cmp(e.name, "BranchCount",  BranchCount,       e.branchCnt);
    cmp(e.name, "MispredCount", MispredCount,      e.mispredCnt);
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle away from the edge.
  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  task automatic applyStimulus(input logic rst, input logic [31:0] pcf, input logic br,
                               input logic [2:0] f3, input logic zero, input logic [31:0] pce,
                               input logic [31:0] tgt, input logic predE);
    @(posedge clk);
    #1;
    reset      = rst;
    PCF        = pcf;
    BranchE    = br;
    funct3E    = f3;
    ZeroE      = zero;
    PCE        = pce;
    PCTargetE  = tgt;
    PCPlus4E   = pce + 32'd4;
    PredTakenE = predE;
  endtask

  task automatic pushExp(input string name, input logic pt, input logic [31:0] ptg,
                         input logic act, input logic mis, input logic [31:0] red,
                         input logic [31:0] bc, input logic [31:0] mc);
    exp_t e;
    e.name = name; e.predTaken = pt; e.predTarget = ptg; e.actual = act;
    e.mispred = mis; e.redirect = red; e.branchCnt = bc; e.mispredCnt = mc;
    expQ.push_back(e);
  endtask

  initial begin
    reset = 1'b0; PCF = '0; BranchE = 1'b0; funct3E = '0; ZeroE = 1'b0;
    PCE = '0; PCTargetE = '0; PCPlus4E = '0; PredTakenE = 1'b0;
    applyStimulus(0, 32'h100, 0, F3_BEQ, 0, 0, 0, 0);
    applyStimulus(0, 32'h100, 0, F3_BEQ, 0, 0, 0, 0);

    applyStimulus(1, 32'h100, 0, F3_BEQ, 0, 0, 0, 0);
    pushExp("reset", 0, 32'h104, 0, 0, 0, 0, 0);

    applyStimulus(1, 32'h100, 1, F3_BEQ, 1, 32'h100, 32'h80, 0);
    pushExp("alloc", 0, 32'h104, 1, 1, 32'h80, 0, 0);
    applyStimulus(1, 32'h100, 0, F3_BEQ, 0, 0, 0, 0);
    pushExp("allocHit", 1, 32'h80, 0, 0, 0, 1, 1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h100, 1, F3_BEQ, 1, 32'h100, 32'h80, 1);
      pushExp("satTaken", 1, 32'h80, 1, 0, 0, 32'(1 + i), 1);
    end
    applyStimulus(1, 32'h100, 1, F3_BEQ, 0, 32'h100, 32'h80, 1);
    pushExp("satNt1", 1, 32'h80, 0, 1, 32'h104, 4, 1);
    applyStimulus(1, 32'h100, 1, F3_BEQ, 0, 32'h100, 32'h80, 1);
    pushExp("satNt2", 1, 32'h80, 0, 1, 32'h104, 5, 2);
    applyStimulus(1, 32'h100, 0, F3_BEQ, 0, 0, 0, 0);
    pushExp("satDrop", 0, 32'h104, 0, 0, 0, 6, 3);

    applyStimulus(1, 32'h100, 1, F3_BEQ, 1, 32'h140, 32'h200, 0);
    pushExp("alias", 0, 32'h104, 1, 1, 32'h200, 6, 3);
    applyStimulus(1, 32'h100, 0, F3_BEQ, 0, 0, 0, 0);
    pushExp("aliasOld", 0, 32'h104, 0, 0, 0, 7, 4);
    applyStimulus(1, 32'h140, 0, F3_BEQ, 0, 0, 0, 0);
    pushExp("aliasNew", 1, 32'h200, 0, 0, 0, 7, 4);

    applyStimulus(1, 32'h140, 1, F3_BLT, 0, 32'h204, 32'h300, 0);
    pushExp("blt", 1, 32'h200, 1, 1, 32'h300, 7, 4);
    applyStimulus(1, 32'h140, 1, F3_BGEU, 0, 32'h208, 32'h400, 0);
    pushExp("bgeu", 1, 32'h200, 0, 0, 0, 8, 5);
    applyStimulus(1, 32'h20C, 1, 3'b010, 1, 32'h20C, 32'h500, 1);
    pushExp("illegal", 0, 32'h210, 0, 0, 0, 9, 5);
    applyStimulus(1, 32'h20C, 0, F3_BEQ, 0, 0, 0, 0);
    pushExp("illegalNoUpd", 0, 32'h210, 0, 0, 0, 9, 5);

    applyStimulus(1, 32'h204, 1, F3_BEQ, 0, 32'h204, 32'h300, 1);
    pushExp("sameCycle", 1, 32'h300, 0, 1, 32'h208, 9, 5);
    applyStimulus(1, 32'h204, 0, F3_BEQ, 0, 0, 0, 0);
    pushExp("sameCycleNext", 0, 32'h208, 0, 0, 0, 10, 6);

    applyStimulus(0, 32'h100, 1, F3_BEQ, 1, 32'h100, 32'h80, 0);
    applyStimulus(1, 32'h100, 0, F3_BEQ, 0, 0, 0, 0);
    pushExp("rstBeatsUpd", 0, 32'h104, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h140, 0, F3_BEQ, 0, 0, 0, 0);
    pushExp("rstClrAlias", 0, 32'h144, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      if (expQ.size() == 0) break;
      @(negedge clk);
    end
    #1;
    if (expQ.size() != 0) begin
      checksTotal++;
      $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
    end
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
